// File: rtl/noc_rr_timeout_arbiter_if.sv
// Arbiter port bundle: requester side drives req/flit_id/length, arbiter
// side returns the registered grant, its index and the timeout pulses.
interface noc_rr_timeout_arbiter_if #(
  parameter int NPORTS = 5,
  parameter int LEN_W  = 12,
  parameter int FID_W  = 3,
  parameter int IDX_W  = $clog2(NPORTS)
);
  logic [NPORTS-1:0]       req;
  logic [NPORTS*FID_W-1:0] flit_id;
  logic [NPORTS*LEN_W-1:0] length;
  logic [NPORTS-1:0]       grant;
  logic                    grant_valid;
  logic [IDX_W-1:0]        grant_idx;
  logic [NPORTS-1:0]       timeout_pulse;

  modport master (
    output req, flit_id, length,
    input  grant, grant_valid, grant_idx, timeout_pulse
  );

  modport slave (
    input  req, flit_id, length,
    output grant, grant_valid, grant_idx, timeout_pulse
  );
endinterface

// File: rtl/noc_rr_timeout_arbiter.sv
// Round-robin output-port arbiter with per-port hold timers. Each channel
// keeps the grant while it requests and its counter has not reached the
// limit taken from its latest header flit.

// Per-port hold timer: limit register plus hold counter.
module noc_rr_port_timer #(
  parameter int LEN_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hdr,
  input  logic [LEN_W-1:0] len,
  input  logic             hold,
  output logic             exp
);
  logic [LEN_W-1:0] lim;
  logic [LEN_W-1:0] cnt;

  // Limit tracks every header flit; counter runs only while this port holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      lim <= '0;
      cnt <= '0;
    end else begin
      if (hdr) lim <= len;
      cnt <= hold ? cnt + LEN_W'(1) : '0;
    end
  end

  // Expiry compares against the registered limit, so a header loaded this
  // cycle only matters from the next one.
  assign exp = (cnt == lim);
endmodule

module noc_rr_timeout_arbiter #(
  parameter int NPORTS    = 5,
  parameter int LEN_W     = 12,
  parameter int FID_W     = 3,
  parameter int HEADER_ID = 1,
  parameter int IDX_W     = $clog2(NPORTS)
) (
  input logic                   clk,
  input logic                   rst,
  noc_rr_timeout_arbiter_if.slave bus
);
  logic [NPORTS-1:0] grant_q, grant_d;
  logic [NPORTS-1:0] tp_q, tp_d;
  logic [NPORTS-1:0] hold, exp;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [IDX_W-1:0]  base, cand, pick;
  logic              vld_q, found;

  // One timer per channel.
  for (genvar k = 0; k < NPORTS; k++) begin : g_port
    noc_rr_port_timer #(.LEN_W(LEN_W)) u_tmr (
      .clk  (clk),
      .rst  (rst),
      .hdr  (bus.flit_id[k*FID_W +: FID_W] == FID_W'(HEADER_ID)),
      .len  (bus.length[k*LEN_W +: LEN_W]),
      .hold (hold[k]),
      .exp  (exp[k])
    );
  end

  // Only the current holder can have a hold bit set.
  assign hold = grant_q & bus.req & ~exp;
  // From idle rotate after the last winner; on hand-over rotate after the holder.
  assign base = vld_q ? idx_q : last_q;

  // Next-grant selection: hold, otherwise first requester in rotation order.
  always_comb begin
    grant_d = '0;
    idx_d   = '0;
    last_d  = last_q;
    tp_d    = grant_q & bus.req & exp;
    found   = 1'b0;
    pick    = '0;
    cand    = '0;
    if (|hold) begin
      grant_d = grant_q;
      idx_d   = idx_q;
    end else begin
      // On hand-over the current holder (i == NPORTS) is skipped.
      for (int i = 1; i <= NPORTS; i++) begin
        cand = IDX_W'((int'(base) + i) % NPORTS);
        if (!found && (i < NPORTS || !vld_q) && bus.req[cand]) begin
          found = 1'b1;
          pick  = cand;
        end
      end
      if (found) begin
        grant_d[pick] = 1'b1;
        idx_d         = pick;
        last_d        = pick;
      end
    end
  end

  // Grant, index, valid and pulse all update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      tp_q    <= '0;
      last_q  <= IDX_W'(NPORTS - 1);
    end else begin
      grant_q <= grant_d;
      idx_q   <= idx_d;
      vld_q   <= |grant_d;
      tp_q    <= tp_d;
      last_q  <= last_d;
    end
  end

  assign bus.grant         = grant_q;
  assign bus.grant_valid   = vld_q;
  assign bus.grant_idx     = idx_q;
  assign bus.timeout_pulse = tp_q;
endmodule

// File: tb/tb_noc_rr_timeout_arbiter.sv
// Bench for the round-robin timeout arbiter: a 5-port and an 8-port instance
// run side by side against an owner/last/limit/count reference model.
module tb_noc_rr_timeout_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]  req5 = '0;
  logic [14:0] fid5 = '0;
  logic [59:0] len5 = '0;
  logic [7:0]  req8 = '0;
  logic [23:0] fid8 = '0;
  logic [95:0] len8 = '0;

  noc_rr_timeout_arbiter_if #(.NPORTS(5)) if5 ();
  noc_rr_timeout_arbiter_if #(.NPORTS(8)) if8 ();
  assign if5.req = req5;  assign if5.flit_id = fid5;  assign if5.length = len5;
  assign if8.req = req8;  assign if8.flit_id = fid8;  assign if8.length = len8;

  noc_rr_timeout_arbiter #(.NPORTS(5)) dut5 (.clk(clk), .rst(rst), .bus(if5.slave));
  noc_rr_timeout_arbiter #(.NPORTS(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model, index 0 = 5-port, 1 = 8-port. owner = -1 means idle.
  int         m_owner [2];
  int         m_last  [2];
  int         m_lim   [2][8];
  int         m_cnt   [2][8];
  logic [7:0] m_tp    [2];

  task automatic mreset(input int u, input int n);
    m_owner[u] = -1;
    m_last[u]  = n - 1;
    m_tp[u]    = '0;
    for (int k = 0; k < 8; k++) begin
      m_lim[u][k] = 0;
      m_cnt[u][k] = 0;
    end
  endtask

  task automatic mstep(input int u, input int n, input logic [7:0] rq,
                       input logic [7:0] hdr, input int ln [8]);
    int o, nw, j;
    logic [7:0] tp;
    o  = m_owner[u];
    nw = -1;
    tp = '0;
    if (o >= 0 && rq[o] && m_cnt[u][o] != m_lim[u][o]) begin
      nw = o;
    end else begin
      if (o >= 0 && rq[o]) tp[o] = 1'b1;
      if (o >= 0) begin
        for (int i = 1; i < n; i++) begin
          j = (o + i) % n;
          if (nw < 0 && rq[j]) nw = j;
        end
      end else begin
        for (int i = 1; i <= n; i++) begin
          j = (m_last[u] + i) % n;
          if (nw < 0 && rq[j]) nw = j;
        end
      end
    end
    for (int k = 0; k < n; k++) begin
      m_cnt[u][k] = (o >= 0 && k == o && nw == o) ? m_cnt[u][k] + 1 : 0;
      if (hdr[k]) m_lim[u][k] = ln[k];
    end
    m_owner[u] = nw;
    if (nw >= 0) m_last[u] = nw;
    m_tp[u] = tp;
  endtask

  function automatic logic [31:0] eg(input int u);
    return (m_owner[u] >= 0) ? (32'd1 << m_owner[u]) : 32'd0;
  endfunction

  function automatic logic [31:0] ei(input int u);
    return (m_owner[u] >= 0) ? 32'(m_owner[u]) : 32'd0;
  endfunction

  task automatic cmp_all();
    chk("grant5", 32'(if5.grant),         eg(0));
    chk("valid5", 32'(if5.grant_valid),   32'(m_owner[0] >= 0));
    chk("idx5",   32'(if5.grant_idx),     ei(0));
    chk("tp5",    32'(if5.timeout_pulse), 32'(m_tp[0]));
    chk("grant8", 32'(if8.grant),         eg(1));
    chk("valid8", 32'(if8.grant_valid),   32'(m_owner[1] >= 0));
    chk("idx8",   32'(if8.grant_idx),     ei(1));
    chk("tp8",    32'(if8.timeout_pulse), 32'(m_tp[1]));
  endtask

  // One clock: sample the driven inputs into the model, then compare #1 later.
  task automatic step();
    int ln5 [8];
    int ln8 [8];
    logic [7:0] h5, h8;
    for (int k = 0; k < 8; k++) begin
      ln5[k] = 0;
      h5[k]  = 1'b0;
      if (k < 5) begin
        h5[k]  = (fid5[k*3 +: 3] == 3'd1);
        ln5[k] = int'(len5[k*12 +: 12]);
      end
      h8[k]  = (fid8[k*3 +: 3] == 3'd1);
      ln8[k] = int'(len8[k*12 +: 12]);
    end
    @(posedge clk);
    if (rst) begin
      mreset(0, 5);
      mreset(1, 8);
    end else begin
      mstep(0, 5, {3'b000, req5}, h5, ln5);
      mstep(1, 8, req8, h8, ln8);
    end
    #1;
    cmp_all();
  endtask

  task automatic set5(input int k, input int fid, input int len);
    fid5[k*3 +: 3]   = 3'(fid);
    len5[k*12 +: 12] = 12'(len);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req5 = '0; fid5 = '0; len5 = '0;
    req8 = '0; fid8 = '0; len8 = '0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Rotation with lim = 0: each requester gets one cycle and times out.
    do_reset();
    req5 = 5'b10101;
    step(); chk("t1_g0", 32'(if5.grant), 32'h01); chk("t1_tp0", 32'(if5.timeout_pulse), 32'h00);
    step(); chk("t1_g1", 32'(if5.grant), 32'h04); chk("t1_tp1", 32'(if5.timeout_pulse), 32'h01);
    step(); chk("t1_g2", 32'(if5.grant), 32'h10); chk("t1_tp2", 32'(if5.timeout_pulse), 32'h04);
    step(); chk("t1_g3", 32'(if5.grant), 32'h01); chk("t1_tp3", 32'(if5.timeout_pulse), 32'h10);

    // Lone requester with lim = 3: 4 grant cycles, one idle with pulse, re-grant.
    do_reset();
    set5(2, 1, 3);
    req5 = 5'b00100;
    for (int i = 0; i < 4; i++) begin
      step(); chk("t2_hold", 32'(if5.grant), 32'h04);
    end
    step(); chk("t2_idle", 32'(if5.grant), 32'h00); chk("t2_tp", 32'(if5.timeout_pulse), 32'h04);
    for (int i = 0; i < 4; i++) begin
      step(); chk("t2_regrant", 32'(if5.grant), 32'h04);
    end

    // Request drop hands over immediately with no pulse and a cleared counter.
    do_reset();
    set5(1, 1, 10);
    req5 = 5'b01010;
    step(); chk("t3_g1", 32'(if5.grant), 32'h02);
    set5(1, 0, 0);
    step(); chk("t3_g1b", 32'(if5.grant), 32'h02);
    req5 = 5'b01000;
    step(); chk("t3_g3", 32'(if5.grant), 32'h08); chk("t3_tp", 32'(if5.timeout_pulse), 32'h00);
    chk("t3_cnt1", 32'(dut5.g_port[1].u_tmr.cnt), 32'h0);

    // Limit shrunk below the running count: holder keeps the grant until req drops.
    do_reset();
    set5(0, 1, 8);
    req5 = 5'b00001;
    step();
    set5(0, 0, 0);
    for (int i = 0; i < 4; i++) step();
    chk("t4_cnt4", 32'(dut5.g_port[0].u_tmr.cnt), 32'h4);
    set5(0, 1, 2);
    step();
    set5(0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(); chk("t4_hold", 32'(if5.grant), 32'h01);
    end
    req5 = '0;
    step(); chk("t4_rel", 32'(if5.grant), 32'h00);

    // Reset while port 4 holds clears everything without a pulse.
    do_reset();
    set5(4, 1, 20);
    req5 = 5'b10000;
    step();
    set5(4, 0, 0);
    step(); step();
    chk("t5_held", 32'(if5.grant), 32'h10);
    rst = 1'b1;
    step();
    chk("t5_rst", {if5.grant, if5.grant_valid, 3'(if5.grant_idx), if5.timeout_pulse}, 32'h0);
    rst  = 1'b0;
    req5 = 5'b11111;
    step(); chk("t5_first", 32'(if5.grant), 32'h01);

    // 8 ports: idle search from every last value over all request patterns.
    do_reset();
    for (int l = 0; l < 8; l++) begin
      for (int p = 0; p < 256; p++) begin
        req8 = '0;            step();
        req8 = 8'(1 << l);    step();
        req8 = '0;            step();
        req8 = 8'(p);         step();
      end
    end

    // Random traffic, headers and occasional reset on both instances.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst  = ($urandom_range(0, 299) == 0);
      req5 = 5'($urandom);
      req8 = 8'($urandom);
      for (int k = 0; k < 5; k++) set5(k, $urandom_range(0, 7), $urandom_range(0, 6));
      for (int k = 0; k < 8; k++) begin
        fid8[k*3 +: 3]   = 3'($urandom_range(0, 7));
        len8[k*12 +: 12] = 12'($urandom_range(0, 6));
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
